// File: rtl/disp_pkg.sv
// Shared types and constants for the game-status display controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         LIVES_MAX     = 8;

  // Thermometer code: bit i set for every i below the lives count.
  function automatic logic [7:0] therm8(input logic [3:0] n);
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < LIVES_MAX; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit saturating BCD up/down counter (00..99) with sync clear and enable.
// Latency: value updates on the edge after a pulse; *_nxt shows the value it will take.
// Backpressure: none; inc and dec together cancel, clear wins over everything.
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] ones_nxt,
  output logic [3:0] tens_nxt
);
  import disp_pkg::*;

  logic [3:0] ones;
  logic [3:0] tens;

  // Next count: BCD carry/borrow between digits, saturating at 99 and 00.
  always_comb begin
    ones_nxt = ones;
    tens_nxt = tens;
    if (clr) begin
      ones_nxt = 4'd0;
      tens_nxt = 4'd0;
    end else if (en && inc && !dec) begin
      if (ones != BCD_MAX_DIGIT) begin
        ones_nxt = ones + 4'd1;
      end else if (tens != BCD_MAX_DIGIT) begin
        ones_nxt = 4'd0;
        tens_nxt = tens + 4'd1;
      end
    end else if (en && dec && !inc) begin
      if (ones != 4'd0) begin
        ones_nxt = ones - 4'd1;
      end else if (tens != 4'd0) begin
        ones_nxt = BCD_MAX_DIGIT;
        tens_nxt = tens - 4'd1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else begin
      ones <= ones_nxt;
      tens <= tens_nxt;
    end
  end

endmodule

// File: rtl/disp_ctrl.sv
// Game-status display controller: score, lives, game FSM, LED bar and digit drive.
// Latency: every output is registered from next-state values, one edge after an input pulse.
// Backpressure: none; pulses are consumed every cycle. Optional hiscore via DISP_HISCORE_EN.
module disp_ctrl #(
  parameter int          LIVES_INIT = 3,
  parameter int          BLINK_LOG2 = 22,
  parameter logic [23:0] HIT_CYCLES = 24'd8_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       score_inc,
  input  logic       score_dec,
  input  logic       life_lost,
  output logic [7:0] led,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic       game_over
);
  import disp_pkg::*;

  state_t              state, state_nxt;
  logic [3:0]          lives, lives_nxt;
  logic [23:0]         hit_cnt, hit_cnt_nxt;
  logic [BLINK_LOG2:0] blink_cnt, blink_nxt;
  logic                phase_nxt;
  logic                score_en;
  logic [3:0]          ones_nxt, tens_nxt;
  logic [7:0]          led_nxt;
  logic [3:0]          dig0_nxt, dig1_nxt;
  logic                game_over_nxt;
`ifdef DISP_HISCORE_EN
  logic [7:0]          hiscore, hiscore_nxt;
`endif

  // Score only moves while a game is in play; start clears it from any state.
  assign score_en = (state == RUN) || (state == HIT);

  bcd_counter2 u_score (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .en       (score_en),
    .inc      (score_inc),
    .dec      (score_dec),
    .ones_nxt (ones_nxt),
    .tens_nxt (tens_nxt)
  );

  // Free-running blink counter; its MSB is the blink phase.
  assign blink_nxt = blink_cnt + 1'b1;
  assign phase_nxt = blink_nxt[BLINK_LOG2];

  // State, game registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lives     <= 4'd0;
      hit_cnt   <= 24'd0;
      blink_cnt <= '0;
      led       <= 8'h00;
      dig0      <= 4'd0;
      dig1      <= 4'd0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      lives     <= lives_nxt;
      hit_cnt   <= hit_cnt_nxt;
      blink_cnt <= blink_nxt;
      led       <= led_nxt;
      dig0      <= dig0_nxt;
      dig1      <= dig1_nxt;
      game_over <= game_over_nxt;
    end
  end

  // Next state: start overrides everything; HIT ignores hits until its window expires.
  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives;
    hit_cnt_nxt = hit_cnt;
    if (start) begin
      state_nxt   = RUN;
      lives_nxt   = 4'(LIVES_INIT);
      hit_cnt_nxt = 24'd0;
    end else begin
      case (state)
        RUN: begin
          if (life_lost) begin
            if (lives > 4'd1) begin
              state_nxt   = HIT;
              lives_nxt   = lives - 4'd1;
              hit_cnt_nxt = HIT_CYCLES - 24'd1;
            end else begin
              state_nxt = OVER;
              lives_nxt = 4'd0;
            end
          end
        end
        HIT: begin
          if (hit_cnt == 24'd0) begin
            state_nxt = RUN;
          end else begin
            hit_cnt_nxt = hit_cnt - 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the values the registers take at the coming edge.
  always_comb begin
    led_nxt       = 8'h00;
    dig0_nxt      = ones_nxt;
    dig1_nxt      = tens_nxt;
    game_over_nxt = 1'b0;
    case (state_nxt)
      RUN: led_nxt = therm8(lives_nxt);
      HIT: begin
        // The just-lost life sits at index lives (already decremented, at most 7).
        led_nxt = therm8(lives_nxt);
        led_nxt[lives_nxt[2:0]] = phase_nxt;
      end
      OVER: begin
        led_nxt       = {8{phase_nxt}};
        game_over_nxt = 1'b1;
`ifdef DISP_HISCORE_EN
        if (phase_nxt) begin
          {dig1_nxt, dig0_nxt} = hiscore_nxt;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef DISP_HISCORE_EN
  // Hiscore captures the final score when a game ends; BCD orders like unsigned binary.
  always_comb begin
    hiscore_nxt = hiscore;
    if ((state == RUN) && (state_nxt == OVER) && ({tens_nxt, ones_nxt} > hiscore)) begin
      hiscore_nxt = {tens_nxt, ones_nxt};
    end
  end

  // Hiscore survives start; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hiscore <= 8'h00;
    end else begin
      hiscore <= hiscore_nxt;
    end
  end
`endif

endmodule

// File: doc/disp_ctrl.md
# disp_ctrl

Game-status display controller that sits directly upstream of the CPLD LED/7-segment serial driver and produces its `led[7:0]`, `dig0` and `dig1` inputs. It keeps a two-digit saturating BCD score and a lives counter, and runs a small game-state FSM. It renders lives as a thermometer LED bar, blinks the LED of a lost life during an invulnerability window, and blinks the whole bar on game over.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded on `start`; legal range 1..8.
- `BLINK_LOG2`, 22: blink phase is bit `BLINK_LOG2` of the free-running blink counter.
- `HIT_CYCLES`, 24'd8_000_000: length of the HIT window in clk cycles; ≥1, 24 bits.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse that starts or restarts a game.
- `score_inc`, in, 1: one-cycle pulse, score +1.
- `score_dec`, in, 1: one-cycle pulse, score −1.
- `life_lost`, in, 1: one-cycle pulse, lose one life.
- `led`, out, 8: LED bar to the serial driver.
- `dig0`, out, 4: BCD ones digit.
- `dig1`, out, 4: BCD tens digit.
- `game_over`, out, 1: high while in OVER.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`.
  - RUN → HIT on `life_lost` when lives > 1; lives is decremented.
  - RUN → OVER on `life_lost` when lives == 1; lives becomes 0.
  - HIT → RUN when the hit counter expires.
  - Any state → RUN on `start`: score = 00, lives = `LIVES_INIT`, hit counter cleared.
- `start` has priority over all other inputs in the same cycle.
- Score updates in RUN and HIT only. It is frozen in IDLE and OVER, where `score_inc`/`score_dec` are ignored.
- BCD increment: ones 9 → 0 with tens +1; 99 saturates at 99.
- BCD decrement: ones 0 → 9 with tens −1; 00 saturates at 00.
- `score_inc` and `score_dec` in the same cycle: no change.
- `life_lost` is ignored in IDLE, HIT (invulnerable) and OVER.
- `life_lost` together with `score_inc`/`score_dec`: both take effect in the same cycle.
- Blink counter: free-running, width `BLINK_LOG2+1`, cleared only by `rst`. phase = MSB.
- LED rendering:
  - IDLE: 0x00.
  - RUN: `led[i] = (i < lives)`.
  - HIT: as RUN, plus `led[lives] = phase` (lives already decremented).
  - OVER: all eight bits = phase.
- Digits: `dig1:dig0` = score, except in OVER with the macro enabled (see Configuration).

## Timing
- Reset values: state IDLE, score 00, lives 0, hit counter 0, blink counter 0, `led` 0x00, `dig0`/`dig1` 0, `game_over` 0. The hiscore register is also 00.
- All outputs are registered. An input pulse at edge N is visible on the outputs after edge N+1 (one-cycle latency).
- Hit counter is loaded with `HIT_CYCLES−1` on the HIT entry cycle and decrements each cycle. HIT exits to RUN on the cycle after it reads 0, so HIT lasts exactly `HIT_CYCLES` cycles.
- `game_over` rises on the same edge on which the state becomes OVER. It falls on the `start` edge.
- `rst` mid-game forces the full reset state on the next edge regardless of any other input.

## Configuration
- `DISP_HISCORE_EN` defined:
  - An 8-bit BCD hiscore register, reset to 00 by `rst` only (not by `start`).
  - On the RUN→OVER transition, hiscore is loaded with score if {tens,ones} > hiscore; plain 8-bit unsigned compare is valid for BCD.
  - In OVER, the digits show score while phase = 0 and hiscore while phase = 1.
- Not defined: no hiscore register; the digits always show score.

## Structure
- Package `disp_pkg`:
  - state enum: IDLE, RUN, HIT, OVER.
  - constants: `BCD_MAX_DIGIT = 4'd9`, `LIVES_MAX = 8`.
- Sub-module `bcd_counter2`: two-digit saturating BCD up/down counter with synchronous clear and an enable input. The top level gates the enable with the state.

## Test plan
- Reset then `start` with `LIVES_INIT=3` → `led=0x07`, digits 00, `game_over=0` one cycle after `start`.
- 100 `score_inc` pulses → digits step 01…99 and stay at 99. A following `score_inc` together with `score_dec` → still 99. A single `score_dec` → 98. From 10, `score_dec` → 09.
- `life_lost` in RUN (BLINK_LOG2=2, HIT_CYCLES=10) → `led[1:0]=11`, `led[2]` toggles every 4 cycles. A second `life_lost` during HIT is ignored. RUN resumes after exactly 10 cycles with `led=0x03`.
- Lives down to 1, then `life_lost` → `game_over=1`, `led` alternates 0x00/0xFF, `score_inc` ignored. `start` → `led=0x07`, score 00, `game_over=0`.
- `DISP_HISCORE_EN`: game ends at 42, second game ends at 17 → in OVER the digits alternate 17/42. `rst` → hiscore 00.
- `rst` asserted during HIT together with `start` → full reset state: IDLE, `led=0x00`.
